// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: four-channel TDM receive demultiplexer.
// Recovers frame alignment from a sync marker on the MSB of slot 0,
// deserializes four WIDTH-bit slots (MSB first) and publishes all four
// channel words together once a complete frame has been received without error.
module tdm_demux_4ch #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             sync,
    input  logic             en,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [1:0]       s,
    output logic             frame_valid,
    output logic             sync_err
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0]    ST_HUNT  = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       s_q, s_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] stg0_q, stg0_d;
    logic [WIDTH-1:0] stg1_q, stg1_d;
    logic [WIDTH-1:0] stg2_q, stg2_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [WIDTH-1:0] y2_q, y2_d;
    logic [WIDTH-1:0] y3_q, y3_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    // Current shift contents with the incoming bit appended: the full slot
    // word on the last bit, and the source of the next shift value otherwise.
    logic [WIDTH-1:0] word_s;
    logic             at_sync_point_s;

    // Next-state logic: alignment tracking, slot deserialization, frame publish.
    always_comb begin
        word_s          = {shift_q, din};
        at_sync_point_s = (cnt_q == {CW{1'b0}}) && (s_q == 2'd0);
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        shift_d = shift_q;
        stg0_d  = stg0_q;
        stg1_d  = stg1_q;
        stg2_d  = stg2_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y3_d    = y3_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            case (state_q)
                ST_HUNT: begin
                    if (sync) begin
                        // Sync bit is the MSB of slot 0 of a new frame.
                        state_d = ST_RUN;
                        cnt_d   = CW'(1);
                        s_d     = 2'd0;
                        shift_d = word_s[WIDTH-2:0];
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_RUN: begin
                    if (at_sync_point_s && !sync) begin
                        // Expected marker missing: drop the bit and re-hunt.
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                        cnt_d   = {CW{1'b0}};
                        s_d     = 2'd0;
                    end else if (sync) begin
                        // Marker restarts the frame; it is an error unless it
                        // landed exactly on the expected slot-0 boundary.
                        err_d   = !at_sync_point_s;
                        cnt_d   = CW'(1);
                        s_d     = 2'd0;
                        shift_d = word_s[WIDTH-2:0];
                    end else begin
                        shift_d = word_s[WIDTH-2:0];
                        if (cnt_q == LAST_BIT) begin
                            cnt_d = {CW{1'b0}};
                            s_d   = s_q + 2'd1;
                            case (s_q)
                                2'd0: stg0_d = word_s;
                                2'd1: stg1_d = word_s;
                                2'd2: stg2_d = word_s;
                                2'd3: begin
                                    // Publish all four words at once so the
                                    // outputs never mix two frames.
                                    y0_d = stg0_q;
                                    y1_d = stg1_q;
                                    y2_d = stg2_q;
                                    y3_d = word_s;
                                    fv_d = 1'b1;
                                end
                                default: stg0_d = stg0_q;
                            endcase
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = {CW{1'b0}};
                    s_d     = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HUNT;
            cnt_q   <= {CW{1'b0}};
            s_q     <= 2'd0;
            shift_q <= {(WIDTH-1){1'b0}};
            stg0_q  <= {WIDTH{1'b0}};
            stg1_q  <= {WIDTH{1'b0}};
            stg2_q  <= {WIDTH{1'b0}};
            y0_q    <= {WIDTH{1'b0}};
            y1_q    <= {WIDTH{1'b0}};
            y2_q    <= {WIDTH{1'b0}};
            y3_q    <= {WIDTH{1'b0}};
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            shift_q <= shift_d;
            stg0_q  <= stg0_d;
            stg1_q  <= stg1_d;
            stg2_q  <= stg2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign y0          = y0_q;
    assign y1          = y1_q;
    assign y2          = y2_q;
    assign y3          = y3_q;
    assign s           = s_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;

endmodule
